// File: rtl/bidir_pin_pkg.sv
// -----------------------------------------------------------------------------
// bidir_pin_pkg
// Shared constants and types for the bidirectional pin bank.
//   DEF_*     : default parameter values for bidir_pin_bank
//   TA_CNT_W  : width of the per-bit turnaround counter (covers 0..7)
//   dir_e     : direction encoding of the per-bit dir request
// -----------------------------------------------------------------------------
package bidir_pin_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TURNAROUND  = 1;

  localparam int TA_CNT_W = 3;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;

  typedef logic [TA_CNT_W-1:0] ta_cnt_t;

endpackage

// File: rtl/bidir_pin_cell.sv
// -----------------------------------------------------------------------------
// bidir_pin_cell
// One-bit slice of the pin bank: turnaround counter, registered data/enable,
// push-pull / open-drain pad driver, input synchroniser, edge detector and a
// sticky interrupt flag.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   pin         : pad connection (inout)
//   dir         : requested direction (1 = output)
//   od_en       : open-drain enable, applied combinationally to dq/oe
//   data_out    : value to drive, registered into dq each clock
//   data_in     : synchronised pad value (last synchroniser stage)
//   oe          : registered output enable
//   rise, fall  : single-cycle pulses on data_in transitions
//   irq_en      : allows rise/fall to set the sticky flag
//   irq_clr     : write-one-to-clear for the flag (a simultaneous set wins)
//   irq_status  : sticky edge flag
// -----------------------------------------------------------------------------
module bidir_pin_cell
  import bidir_pin_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TURNAROUND  = DEF_TURNAROUND
) (
  input  logic clk,
  input  logic rst,
  inout  wire  pin,
  input  logic dir,
  input  logic od_en,
  input  logic data_out,
  output logic data_in,
  output logic oe,
  output logic rise,
  output logic fall,
  input  logic irq_en,
  input  logic irq_clr,
  output logic irq_status
);

  localparam ta_cnt_t TA_LAST = ta_cnt_t'(TURNAROUND);

  ta_cnt_t                cnt_q, cnt_d;
  logic                   oe_q, oe_d;
  logic                   dq_q, dq_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   irq_q, irq_d;
  logic                   drive_en;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    cnt_d = '0;
    oe_d  = 1'b0;
    if (dir_e'(dir) == DIR_OUT) begin
      // Count dead cycles while still tri-stated; the enable rises on the
      // edge that sees the counter at TURNAROUND. Dropping dir at any point
      // falls through to the defaults, clearing both counter and enable.
      if (oe_q || (cnt_q == TA_LAST)) begin
        oe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ta_cnt_t'(1);
      end
    end

    dq_d   = data_out;
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    prev_d = data_in;
    // Set term is OR-ed after the clear mask so a coincident edge wins.
    irq_d  = (irq_q & ~irq_clr) | ((rise | fall) & irq_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all flops
    // sample pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q  <= '0;
      oe_q   <= 1'b0;
      dq_q   <= 1'b0;
      sync_q <= '0;
      prev_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      oe_q   <= oe_d;
      dq_q   <= dq_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  // Open-drain only ever drives the low level; the high level is released.
  assign drive_en = oe_q & (~od_en | ~dq_q);
  assign pin      = drive_en ? dq_q : 1'bz;

  assign data_in    = sync_q[SYNC_STAGES-1];
  assign oe         = oe_q;
  assign rise       = data_in & ~prev_q;
  assign fall       = ~data_in & prev_q;
  assign irq_status = irq_q;

endmodule

// File: rtl/bidir_pin_bank.sv
// -----------------------------------------------------------------------------
// bidir_pin_bank
// Bank of WIDTH independent bidirectional pads between the top-level inout
// pins and the GPIO register block. Each bit is a bidir_pin_cell; the bank
// adds only the interrupt OR-reduction.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   pin         : WIDTH pad connections (inout)
//   dir         : per-bit requested direction (1 = output)
//   od_en       : per-bit open-drain enable
//   data_out    : per-bit value to drive
//   data_in     : per-bit synchronised pad value
//   oe          : per-bit registered output enable
//   rise, fall  : per-bit edge pulses on data_in
//   irq_en      : per-bit interrupt enable
//   irq_clr     : per-bit write-one-to-clear
//   irq_status  : per-bit sticky edge flags
//   irq         : OR of irq_status
// -----------------------------------------------------------------------------
module bidir_pin_bank
  import bidir_pin_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TURNAROUND  = DEF_TURNAROUND
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] dir,
  input  logic [WIDTH-1:0] od_en,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] oe,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bidir_pin_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .TURNAROUND  (TURNAROUND)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .pin        (pin[i]),
      .dir        (dir[i]),
      .od_en      (od_en[i]),
      .data_out   (data_out[i]),
      .data_in    (data_in[i]),
      .oe         (oe[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .irq_en     (irq_en[i]),
      .irq_clr    (irq_clr[i]),
      .irq_status (irq_status[i])
    );
  end

  assign irq = |irq_status;

endmodule

// File: tb/tb_bidir_pin_bank.sv
// -----------------------------------------------------------------------------
// tb_bidir_pin_bank
// Scoreboard bench for bidir_pin_bank (WIDTH=4, SYNC_STAGES=2, TURNAROUND=1).
// The stimulus process advances a behavioural model (run lengths of dir=1,
// a history of sampled pad values, sticky flag set) and pushes the expected
// outputs for each cycle; a monitor pops and compares on every falling edge.
// The bench plays the external world on the pads: it drives every bit the
// model says the DUT is not driving.
// -----------------------------------------------------------------------------
module tb_bidir_pin_bank;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int TA = 1;

  typedef struct {
    logic [W-1:0] data_in;
    logic [W-1:0] oe;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] status;
    logic         irq;
    logic [W-1:0] pad;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  wire  [W-1:0] pin;
  logic [W-1:0] dir      = '0;
  logic [W-1:0] od_en    = '0;
  logic [W-1:0] data_out = '0;
  logic [W-1:0] irq_en   = '0;
  logic [W-1:0] irq_clr  = '0;
  logic [W-1:0] data_in, oe, rise, fall, irq_status;
  logic         irq;

  logic [W-1:0] tb_en  = '1;
  logic [W-1:0] tb_val = '0;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int           run_len [W];
  logic [W-1:0] m_dq;
  logic [W-1:0] hist_q[$];
  logic [W-1:0] m_prev;
  logic [W-1:0] m_status;
  logic [W-1:0] m_pad;
  exp_t         exp_q[$];
  exp_t         mon_e;

  for (genvar g = 0; g < W; g++) begin : g_ext
    assign pin[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  always #5 clk = ~clk;

  bidir_pin_bank #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .TURNAROUND  (TA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .dir        (dir),
    .od_en      (od_en),
    .data_out   (data_out),
    .data_in    (data_in),
    .oe         (oe),
    .rise       (rise),
    .fall       (fall),
    .irq_en     (irq_en),
    .irq_clr    (irq_clr),
    .irq_status (irq_status),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) run_len[i] = 0;
    m_dq     = '0;
    m_prev   = '0;
    m_status = '0;
    hist_q.delete();
    for (int k = 0; k < SS; k++) hist_q.push_back('0);
  endtask

  // One active clock edge: uses the inputs held during the cycle just ended.
  task automatic model_edge();
    logic [W-1:0] di, r, f;
    di       = hist_q[0];
    r        = di & ~m_prev;
    f        = ~di & m_prev;
    m_status = (m_status & ~irq_clr) | ((r | f) & irq_en);
    m_prev   = di;
    hist_q.push_back(m_pad);
    void'(hist_q.pop_front());
    m_dq = data_out;
    for (int i = 0; i < W; i++) begin
      if (!dir[i])            run_len[i] = 0;
      else if (run_len[i] < 15) run_len[i] = run_len[i] + 1;
    end
  endtask

  // Expected outputs for the current cycle, given the inputs just applied.
  task automatic predict_and_push();
    logic [W-1:0] eoe, drv;
    exp_t e;
    for (int i = 0; i < W; i++) eoe[i] = (run_len[i] > TA);
    drv      = eoe & (~od_en | ~m_dq);
    m_pad    = (drv & m_dq) | (~drv & tb_val);
    tb_en    = ~drv;
    e.data_in = hist_q[0];
    e.oe      = eoe;
    e.rise    = hist_q[0] & ~m_prev;
    e.fall    = ~hist_q[0] & m_prev;
    e.status  = m_status;
    e.irq     = |m_status;
    e.pad     = m_pad;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [W-1:0] d, od, dout, ien, iclr, tv,
                      input bit set_rst, input bit rel_rst);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    if (rel_rst) rst = 1'b0;
    dir      = d;
    od_en    = od;
    data_out = dout;
    irq_en   = ien;
    irq_clr  = iclr;
    tb_val   = tv;
    if (set_rst) begin
      #1;
      rst = 1'b1;
      model_reset();
    end
    predict_and_push();
    #1;
  endtask

  task automatic st(input logic [W-1:0] d, od, dout, ien, iclr, tv);
    step(d, od, dout, ien, iclr, tv, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sb_data_in", 32'(data_in),    32'(mon_e.data_in));
      check("sb_oe",      32'(oe),         32'(mon_e.oe));
      check("sb_rise",    32'(rise),       32'(mon_e.rise));
      check("sb_fall",    32'(fall),       32'(mon_e.fall));
      check("sb_status",  32'(irq_status), 32'(mon_e.status));
      check("sb_irq",     32'(irq),        32'(mon_e.irq));
      check("sb_pin",     32'(pin),        32'(mon_e.pad));
    end
  end

  initial begin
    logic [W-1:0] r_dir, r_od;
    model_reset();
    m_pad = '0;

    // Reset held with all bits requesting output: nothing may drive.
    repeat (3) begin
      st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
      check("oe_in_reset", 32'(oe), 32'h0);
    end
    check("pin_in_reset", 32'(pin), 32'h5);
    step(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5, 1'b0, 1'b1);
    check("oe_at_release", 32'(oe), 32'h0);
    st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("oe_edge1", 32'(oe), 32'h0);
    st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("oe_edge2", 32'(oe), 32'hF);
    check("pin_driven", 32'(pin), 32'hA);

    // Bit 0 drops, re-requests for one cycle only; bit 1 drops later.
    st(4'hE, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    st(4'hE, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("oe0_drop", 32'(oe), 32'hE);
    st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    st(4'hE, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("oe0_mid_ta", 32'(oe[0]), 32'h0);
    st(4'hE, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("oe0_aborted", 32'(oe[0]), 32'h0);
    check("pin0_released", 32'(pin[0]), 32'h1);
    st(4'hC, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    st(4'hC, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("oe1_drop", 32'(oe), 32'hC);

    // Bit 2 open-drain: a driven 1 releases the pad to the pull-up.
    st(4'hC, 4'h4, 4'hE, 4'h0, 4'h0, 4'h5);
    st(4'hC, 4'h4, 4'hE, 4'h0, 4'h0, 4'h5);
    check("od_release", 32'(pin[2]), 32'h1);
    st(4'hC, 4'h4, 4'hE, 4'h0, 4'h0, 4'h5);
    st(4'hC, 4'h4, 4'hE, 4'h0, 4'h0, 4'h5);
    check("od_readback", 32'(data_in[2]), 32'h1);
    st(4'hC, 4'h4, 4'hA, 4'h0, 4'h0, 4'h5);
    st(4'hC, 4'h4, 4'hA, 4'h0, 4'h0, 4'h5);
    check("od_drive_low", 32'(pin[2]), 32'h0);

    // Bit 3 as input: rise sets the flag, clear, then fall coincident with clear.
    repeat (5) st(4'h4, 4'h4, 4'hA, 4'h0, 4'h0, 4'h5);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'hD);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'hD);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'hD);
    check("rise_data_in", 32'(data_in[3]), 32'h1);
    check("rise_pulse", 32'(rise[3]), 32'h1);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'hD);
    check("rise_one_cycle", 32'(rise[3]), 32'h0);
    check("irq_set", 32'(irq_status), 32'h8);
    check("irq_or", 32'(irq), 32'h1);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h8, 4'hD);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'hD);
    check("irq_cleared", 32'(irq_status), 32'h0);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'h5);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'h5);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h8, 4'h5);
    check("fall_pulse", 32'(fall[3]), 32'h1);
    st(4'h4, 4'h4, 4'hA, 4'h8, 4'h0, 4'h5);
    check("set_wins", 32'(irq_status), 32'h8);

    // Asynchronous reset in the middle of a turnaround count.
    repeat (3) st(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5);
    st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    step(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0);
    check("arst_oe", 32'(oe), 32'h0);
    check("arst_pin", 32'(pin), 32'h5);
    check("arst_data_in", 32'(data_in), 32'h0);
    check("arst_edges", 32'(rise | fall), 32'h0);
    check("arst_status", 32'({irq, irq_status}), 32'h0);
    step(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5, 1'b0, 1'b1);
    st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("arst_full_ta1", 32'(oe), 32'h0);
    st(4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h5);
    check("arst_full_ta2", 32'(oe), 32'hF);

    // Randomised traffic; dir and od_en change rarely so turnarounds complete.
    r_dir = 4'hF;
    r_od  = 4'h0;
    for (int c = 0; c < 800; c++) begin
      bit do_rst, do_rel;
      logic [W-1:0] clr;
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 7) == 0) r_dir[i] = ~r_dir[i];
        if ($urandom_range(0, 15) == 0) r_od[i] = ~r_od[i];
        clr[i] = ($urandom_range(0, 3) == 0);
      end
      do_rel = rst;
      do_rst = !rst && ($urandom_range(0, 99) == 0);
      step(r_dir, r_od, W'($urandom), W'($urandom), clr, W'($urandom), do_rst, do_rel);
    end
    if (rst) step(r_dir, r_od, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
